// File: rtl/song_play_ctrl.sv
// Electric-piano playback controller: sequences four song players, paces them with a beat strobe,
// and merges the selected song note with the live key. Optional macro: SONG_AUTO_ADVANCE_EN.
module song_play_ctrl #(
  parameter int         CLK_HZ     = 50000000,
  parameter int         BEAT_HZ    = 8,
  parameter int         SONG_BEATS = 576,
  parameter logic [4:0] REST_CODE  = 5'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_note,
  input  logic       btn_play,
  input  logic       btn_next,
  input  logic       btn_stop,
  input  logic [4:0] song_data0,
  input  logic [4:0] song_data1,
  input  logic [4:0] song_data2,
  input  logic [4:0] song_data3,
  output logic [3:0] song_en,
  output logic       beat_tick,
  output logic [1:0] song_sel,
  output logic [4:0] note_out,
  output logic       note_src,
  output logic       playing
);

  localparam int DIV_RAW = CLK_HZ / BEAT_HZ;
  localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
  localparam int DIV_W   = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SWITCH, S_PLAY, S_PAUSE} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             key_held;
  logic             div_run;
  logic [4:0]       song_note;

  function automatic logic [3:0] onehot(input logic [1:0] sel);
    onehot = 4'b0001 << sel;
  endfunction

  assign key_held  = (key_note != REST_CODE);
  // A held key freezes the song in place, so the divider only runs while flushing or playing unobstructed.
  assign div_run   = (state == S_SWITCH) || ((state == S_PLAY) && !key_held);
  assign beat_tick = div_run && (div_cnt == DIV_LAST);

  always_comb begin
    song_note = song_data0;
    case (song_sel)
      2'd0:    song_note = song_data0;
      2'd1:    song_note = song_data1;
      2'd2:    song_note = song_data2;
      default: song_note = song_data3;
    endcase
  end

`ifdef SONG_AUTO_ADVANCE_EN
  localparam int BCNT_W = $clog2(SONG_BEATS + 1);
  localparam logic [BCNT_W-1:0] BEATS_LAST = BCNT_W'(SONG_BEATS);

  logic [BCNT_W-1:0] beat_cnt;
  logic [BCNT_W-1:0] beat_inc;

  assign beat_inc = beat_cnt + 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      song_sel <= 2'd0;
      song_en  <= 4'd0;
      playing  <= 1'b0;
      div_cnt  <= '0;
      note_out <= REST_CODE;
      note_src <= 1'b0;
`ifdef SONG_AUTO_ADVANCE_EN
      beat_cnt <= '0;
`endif
    end else begin
      if (div_run)
        div_cnt <= beat_tick ? '0 : div_cnt + 1'b1;

      if (key_held) begin
        note_out <= key_note;
        note_src <= 1'b0;
      end else if (state == S_PLAY) begin
        note_out <= song_note;
        note_src <= 1'b1;
      end else begin
        note_out <= REST_CODE;
        note_src <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!btn_stop) begin
            if (btn_next) begin
              song_sel <= song_sel + 2'd1;
            end else if (btn_play) begin
              state   <= S_SWITCH;
              div_cnt <= '0;
            end
          end
        end

        S_SWITCH: begin
          if (btn_stop) begin
            state <= S_IDLE;
          end else if (btn_next) begin
            song_sel <= song_sel + 2'd1;
            div_cnt  <= '0;
          end else if (beat_tick) begin
            state   <= S_PLAY;
            song_en <= onehot(song_sel);
            playing <= 1'b1;
          end
        end

        S_PLAY: begin
          if (btn_stop) begin
            state   <= S_IDLE;
            song_en <= 4'd0;
            playing <= 1'b0;
`ifdef SONG_AUTO_ADVANCE_EN
            beat_cnt <= '0;
`endif
          end else if (btn_next) begin
            state    <= S_SWITCH;
            song_sel <= song_sel + 2'd1;
            song_en  <= 4'd0;
            playing  <= 1'b0;
            div_cnt  <= '0;
`ifdef SONG_AUTO_ADVANCE_EN
            beat_cnt <= '0;
`endif
          end else if (btn_play) begin
            state   <= S_PAUSE;
            playing <= 1'b0;
`ifdef SONG_AUTO_ADVANCE_EN
            // The players still see this tick; count it unless it would complete the song while pausing.
            if (beat_tick && (beat_inc != BEATS_LAST))
              beat_cnt <= beat_inc;
`endif
          end
`ifdef SONG_AUTO_ADVANCE_EN
          else if (beat_tick) begin
            if (beat_inc == BEATS_LAST) begin
              state    <= S_SWITCH;
              song_sel <= song_sel + 2'd1;
              song_en  <= 4'd0;
              playing  <= 1'b0;
              div_cnt  <= '0;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_inc;
            end
          end
`endif
        end

        S_PAUSE: begin
          if (btn_stop) begin
            state   <= S_IDLE;
            song_en <= 4'd0;
`ifdef SONG_AUTO_ADVANCE_EN
            beat_cnt <= '0;
`endif
          end else if (btn_next) begin
            state    <= S_SWITCH;
            song_sel <= song_sel + 2'd1;
            song_en  <= 4'd0;
            div_cnt  <= '0;
`ifdef SONG_AUTO_ADVANCE_EN
            beat_cnt <= '0;
`endif
          end else if (btn_play) begin
            state   <= S_PLAY;
            playing <= 1'b1;
          end
        end

        default: begin
          state   <= S_IDLE;
          song_en <= 4'd0;
          playing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_play_ctrl.sv
// Directed bench for song_play_ctrl with CLK_HZ=8, BEAT_HZ=2 (four clocks per beat).
`timescale 1ns/1ps
module tb_song_play_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] key_note;
  logic       btn_play, btn_next, btn_stop;
  logic [4:0] song_data0, song_data1, song_data2, song_data3;
  logic [3:0] song_en;
  logic       beat_tick;
  logic [1:0] song_sel;
  logic [4:0] note_out;
  logic       note_src;
  logic       playing;

  int n_checks = 0;
  int n_errors = 0;

  song_play_ctrl #(
    .CLK_HZ(8), .BEAT_HZ(2), .SONG_BEATS(3), .REST_CODE(5'd0)
  ) dut (
    .clk(clk), .rst(rst), .key_note(key_note),
    .btn_play(btn_play), .btn_next(btn_next), .btn_stop(btn_stop),
    .song_data0(song_data0), .song_data1(song_data1),
    .song_data2(song_data2), .song_data3(song_data3),
    .song_en(song_en), .beat_tick(beat_tick), .song_sel(song_sel),
    .note_out(note_out), .note_src(note_src), .playing(playing)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_play();
    btn_play = 1'b1; step(); btn_play = 1'b0;
  endtask

  task automatic press_next();
    btn_next = 1'b1; step(); btn_next = 1'b0;
  endtask

  task automatic press_stop();
    btn_stop = 1'b1; step(); btn_stop = 1'b0;
  endtask

  // From SWITCH cycle 1: checks the four flush clocks, then lands in PLAY.
  task automatic flush_beat(input string tag);
    for (int i = 1; i <= 4; i++) begin
      check_val({tag, "_en0"}, song_en, 4'd0);
      check_val({tag, "_tick"}, beat_tick, (i == 4) ? 1 : 0);
      step();
    end
  endtask

  initial begin
    rst = 1'b1; key_note = 5'd0;
    btn_play = 1'b0; btn_next = 1'b0; btn_stop = 1'b0;
    song_data0 = 5'd18; song_data1 = 5'd5; song_data2 = 5'd7; song_data3 = 5'd11;
    @(negedge clk); @(negedge clk);
    check_val("rst_en", song_en, 0);
    check_val("rst_sel", song_sel, 0);
    check_val("rst_tick", beat_tick, 0);
    check_val("rst_note", note_out, 0);
    check_val("rst_src", note_src, 0);
    check_val("rst_play", playing, 0);
    rst = 1'b0;
    step();

    // Start song 0
    press_play();
    flush_beat("sw0");
    check_val("play_en", song_en, 4'b0001);
    check_val("play_playing", playing, 1);
    check_val("play_src_lat", note_src, 0);
    step();
    check_val("play_note", note_out, 18);
    check_val("play_src", note_src, 1);
    check_val("play_tick_off", beat_tick, 0);
    step(); step();
    check_val("play_tick_on", beat_tick, 1);

    // Key override at the tick phase
    key_note = 5'd9; #1;
    check_val("key_tick_supp", beat_tick, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("key_note", note_out, 9);
      check_val("key_src", note_src, 0);
      check_val("key_tick", beat_tick, 0);
    end
    key_note = 5'd0; #1;
    check_val("rel_tick_phase", beat_tick, 1);
    step();
    check_val("rel_note", note_out, 18);
    check_val("rel_src", note_src, 1);
    step(); step(); step();
    check_val("rel_tick_next", beat_tick, 1);

    // Pause at divider phase 1, resume keeps the phase
    step(); step();
    press_play();
    check_val("pause_playing", playing, 0);
    check_val("pause_en", song_en, 4'b0001);
    check_val("pause_tick", beat_tick, 0);
    step();
    check_val("pause_note", note_out, 0);
    check_val("pause_src", note_src, 0);
    step(); step();
    check_val("pause_tick_hold", beat_tick, 0);
    press_play();
    check_val("resume_playing", playing, 1);
    check_val("resume_tick_early", beat_tick, 0);
    step();
    check_val("resume_tick", beat_tick, 1);

    // Stop, select song 3 in IDLE, play it
    press_stop();
    check_val("stop_playing", playing, 0);
    check_val("stop_en", song_en, 0);
    press_next(); press_next(); press_next();
    check_val("idle_sel3", song_sel, 3);
    check_val("idle_tick", beat_tick, 0);
    press_play();
    flush_beat("sw3");
    check_val("play3_en", song_en, 4'b1000);
    step();
    check_val("play3_note", note_out, 11);

    // Next from song 3 wraps to song 0 through a full flush beat
    press_next();
    check_val("wrap_sel", song_sel, 0);
    check_val("wrap_playing", playing, 0);
    flush_beat("swwrap");
    check_val("wrap_en", song_en, 4'b0001);

    // Stop beats next
    btn_stop = 1'b1; btn_next = 1'b1; step(); btn_stop = 1'b0; btn_next = 1'b0;
    check_val("stopnext_playing", playing, 0);
    check_val("stopnext_en", song_en, 0);
    check_val("stopnext_sel", song_sel, 0);

    // Reset mid-song, between clock edges
    press_next();
    press_play();
    flush_beat("sw1");
    check_val("play1_en", song_en, 4'b0010);
    step();
    check_val("play1_note", note_out, 5);
    #2 rst = 1'b1; #1;
    check_val("amid_en", song_en, 0);
    check_val("amid_sel", song_sel, 0);
    check_val("amid_note", note_out, 0);
    check_val("amid_src", note_src, 0);
    check_val("amid_playing", playing, 0);
    check_val("amid_tick", beat_tick, 0);
    @(negedge clk); rst = 1'b0;
    step();
    check_val("post_rst_playing", playing, 0);
    check_val("post_rst_en", song_en, 0);

`ifdef SONG_AUTO_ADVANCE_EN
    press_play();
    flush_beat("swauto");
    step(); step(); step();
    check_val("auto_tick1", beat_tick, 1);
    step(); step();
    press_play();
    step(); step();
    press_play();
    step();
    check_val("auto_tick2", beat_tick, 1);
    step(); step(); step(); step();
    check_val("auto_tick3", beat_tick, 1);
    check_val("auto_pre_playing", playing, 1);
    step();
    check_val("auto_sel", song_sel, 1);
    check_val("auto_playing", playing, 0);
    check_val("auto_en", song_en, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/song_play_ctrl.md
Name: song_play_ctrl

Overview:
- Playback controller for the electric piano.
- Sequences four song players, each driven by an enable and a beat-rate advance strobe, and selects one active song.
- Merges the selected song's 5-bit note code with the live keyboard note, giving the live key priority.
- Drives the single note code consumed by the tone generator.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- BEAT_HZ, 8: beat (shortest note) rate in Hz. DIV = CLK_HZ/BEAT_HZ, minimum 2.
- SONG_BEATS, 576: beats per song, used only by the optional feature.
- REST_CODE, 0: note code meaning silence or no key.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- key_note, input, 5: live keyboard note code; REST_CODE means no key.
- btn_play, input, 1: one-cycle pulse, debounced upstream; play/pause toggle.
- btn_next, input, 1: one-cycle pulse; go to the next song.
- btn_stop, input, 1: one-cycle pulse; stop.
- song_data0..song_data3, input, 5 each: note codes from song players 0..3.
- song_en, output, 4: one-hot ifplay to the players. A player restarts from beat 1 when its enable is low on a beat_tick.
- beat_tick, output, 1: one-clk strobe. Players advance only on clocks where it is 1.
- song_sel, output, 2: current song index.
- note_out, output, 5: registered note to the tone generator.
- note_src, output, 1: 0 = live key or rest, 1 = song.
- playing, output, 1: high in PLAY.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high.
- Reset values: state IDLE, song_sel 0, song_en 0, beat_tick 0, note_out REST_CODE, note_src 0, playing 0, divider 0.
- Divider: counts 0..DIV-1. beat_tick = 1 on the clock where the count equals DIV-1, then the count wraps to 0. It runs only in SWITCH and in PLAY with no key held. It is frozen otherwise and cleared on entry to SWITCH.
- IDLE:
  - song_en = 0.
  - btn_play -> SWITCH.
  - btn_next -> song_sel+1, stay IDLE.
- SWITCH (flush):
  - song_en = 0 so every player resets.
  - On beat_tick -> PLAY, song_en[song_sel] = 1.
  - btn_stop -> IDLE. btn_next -> song_sel+1, stay SWITCH, divider cleared.
- PLAY:
  - song_en one-hot on song_sel, playing = 1.
  - btn_play -> PAUSE. btn_next -> song_sel+1, SWITCH. btn_stop -> IDLE.
- PAUSE:
  - song_en held, divider frozen, beat_tick 0.
  - btn_play -> PLAY, resuming the divider from its frozen count.
  - btn_next -> song_sel+1, SWITCH. btn_stop -> IDLE.
- Button priority when pulses coincide: stop > next > play. Only one transition per clock.
- song_sel wraps 3 -> 0 with modulo-4 arithmetic.
- Note merge (registered, 1-clk latency from key_note or song_data change):
  - key_note != REST_CODE: note_out = key_note, note_src = 0, in any state.
  - else in PLAY: note_out = song_data[song_sel], note_src = 1.
  - else: note_out = REST_CODE, note_src = 0.
- Key override in PLAY: while key_note != REST_CODE the divider freezes and beat_tick is suppressed, so the song holds its position. On release the song resumes from the frozen count on the next clock.
- Buttons during key override act normally.
- Reset mid-song: all outputs return to reset values asynchronously. Players see song_en = 0 and restart on the next play.

Optional Feature:
- Macro: SONG_AUTO_ADVANCE_EN.
- Defined:
  - A beat counter (width ceil(log2(SONG_BEATS+1))) counts beat_ticks in PLAY. It is cleared on entry to SWITCH or IDLE and held in PAUSE and under key override.
  - On the beat_tick that makes it equal SONG_BEATS: song_sel+1 and -> SWITCH. A simultaneous button takes priority over auto-advance.
- Not defined: no counter. The song plays until a button; players loop internally.

Test Plan (CLK_HZ=8, BEAT_HZ=2, so DIV=4):
- Reset, then btn_play -> song_en 0 for 4 clks (SWITCH), beat_tick on clk 4, then song_en=0001, playing=1, and a beat_tick every 4 clks. song_data0=18 -> note_out=18, note_src=1 one clk later.
- In PLAY, key_note=9 for 10 clks -> note_out=9, note_src=0 after 1 clk, no beat_tick during hold. Release -> note_out=song_data0 next clk and ticks resume at the same phase.
- btn_play in PLAY -> PAUSE, beat_tick 0, note_out REST_CODE, song_en still 0001. btn_play again -> resumes with the same divider phase.
- btn_next with song_sel=3 in PLAY -> song_sel=0, song_en 0 for one full beat, then 0001. btn_stop and btn_next in the same clk -> IDLE, song_sel unchanged.
- rst asserted mid-PLAY between clock edges -> all outputs at reset values immediately, state IDLE.
- With SONG_AUTO_ADVANCE_EN and SONG_BEATS=3: after 3 beat_ticks in PLAY -> song_sel+1 and SWITCH. Pause between ticks 1 and 2 -> advance still occurs after exactly 3 ticks.
